// File: rtl/opm_pkg.sv
// Shared types and parameter defaults for the jt51 (OPM) register write scheduler.
// Holds the sequencer state enum, the queued-write record and default timings.
package opm_pkg;

    localparam int DEF_FIFO_DEPTH   = 8;
    localparam int DEF_GAP_CYC      = 2;
    localparam int DEF_MIN_WAIT     = 4;
    localparam int DEF_BUSY_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_GAP,
        ST_DATA,
        ST_WAIT,
        ST_POLL
    } state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

endpackage

// File: rtl/opm_wr_fifo.sv
// Synchronous FIFO of pending OPM register writes (no pass-through when full).
// Ports: clk, rst_n, push/wdata in, pop in, rdata (head), full, empty, level out.
module opm_wr_fifo
    import opm_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wr_t                      wdata,
    input  logic                     pop,
    output wr_t                      rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    wr_t            mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/opm_write_sched.sv
// Queues host register writes and replays them onto the jt51 CPU port with
// address/data strobes, settle gap, busy polling and a sticky busy-timeout flag.
// Ports: ymclk, rst_n; req_valid/req_ready/req_addr/req_data host side;
// opm_cs_n/opm_wr_n/opm_a0/opm_din/opm_dout chip side; err_clr, idle, level, timeout_err.
module opm_write_sched
    import opm_pkg::*;
#(
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int GAP_CYC      = DEF_GAP_CYC,
    parameter int MIN_WAIT     = DEF_MIN_WAIT,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                          ymclk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [7:0]                    req_addr,
    input  logic [7:0]                    req_data,
    output logic                          opm_cs_n,
    output logic                          opm_wr_n,
    output logic                          opm_a0,
    output logic [7:0]                    opm_din,
    input  logic [7:0]                    opm_dout,
    input  logic                          err_clr,
    output logic                          idle,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          timeout_err
);

    localparam int CW = $clog2(BUSY_TIMEOUT + GAP_CYC + MIN_WAIT + 1) + 1;
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MIN_WAIT - 1);
    localparam logic [CW-1:0] POLL_LAST = CW'(BUSY_TIMEOUT - 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    wr_t             head;
    wr_t             hold;
    wr_t             cur;
    logic            full;
    logic            empty;
    logic            pop;
    logic            timeout;
    logic [7:0]      last_addr;
    logic            last_valid;
    logic            strobe_nxt;
    logic            unused_status;

    assign unused_status = ^opm_dout[6:0];
    assign req_ready     = rst_n && !full;
    assign idle          = empty && (state == ST_IDLE);

    opm_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ymclk),
        .rst_n (rst_n),
        .push  (req_valid),
        .wdata ({req_addr, req_data}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // In IDLE the entry being launched is still at the FIFO head.
    assign cur        = (state == ST_IDLE) ? head : hold;
    assign strobe_nxt = (state_nxt == ST_ADDR) || (state_nxt == ST_DATA);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    cnt_nxt = '0;
                    // Same register as last time: chip already holds the address.
                    if (last_valid && head.addr == last_addr)
                        state_nxt = ST_DATA;
                    else
                        state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                cnt_nxt   = '0;
                state_nxt = (GAP_CYC == 0) ? ST_DATA : ST_GAP;
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) state_nxt = ST_DATA;
                else                 cnt_nxt   = cnt + 1'b1;
            end
            ST_DATA: begin
                cnt_nxt   = '0;
                state_nxt = (MIN_WAIT == 0) ? ST_POLL : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_nxt = ST_POLL;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            ST_POLL: begin
                if (!opm_dout[7]) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == POLL_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ymclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (pop) hold <= head;
        end
    end

    // Bus pins are registered against the next state so they are glitch-free;
    // the async reset still forces the strobes high immediately.
    always_ff @(posedge ymclk or negedge rst_n) begin
        if (!rst_n) begin
            opm_cs_n <= 1'b1;
            opm_wr_n <= 1'b1;
            opm_a0   <= 1'b0;
            opm_din  <= '0;
        end else begin
            opm_cs_n <= !strobe_nxt;
            opm_wr_n <= !strobe_nxt;
            if (state_nxt == ST_ADDR) begin
                opm_a0  <= 1'b0;
                opm_din <= cur.addr;
            end else if (state_nxt == ST_DATA) begin
                opm_a0  <= 1'b1;
                opm_din <= cur.data;
            end
        end
    end

    always_ff @(posedge ymclk or negedge rst_n) begin
        if (!rst_n) begin
            last_addr   <= '0;
            last_valid  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ST_DATA) begin
                last_addr  <= hold.addr;
                last_valid <= 1'b1;
            end else if (timeout) begin
                last_valid <= 1'b0;
            end
            if (timeout)      timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_opm_write_sched.sv
// Self-checking bench for opm_write_sched: directed scenarios plus random traffic
// against a queue-based model of the expected strobe sequence.
module tb_opm_write_sched;

    logic       ymclk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       opm_cs_n;
    logic       opm_wr_n;
    logic       opm_a0;
    logic [7:0] opm_din;
    logic [7:0] opm_dout;
    logic       err_clr;
    logic       idle;
    logic [3:0] level;
    logic       timeout_err;

    opm_write_sched dut (
        .ymclk       (ymclk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .opm_cs_n    (opm_cs_n),
        .opm_wr_n    (opm_wr_n),
        .opm_a0      (opm_a0),
        .opm_din     (opm_din),
        .opm_dout    (opm_dout),
        .err_clr     (err_clr),
        .idle        (idle),
        .level       (level),
        .timeout_err (timeout_err)
    );

    initial ymclk = 1'b0;
    always #5 ymclk = ~ymclk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    logic       acc_flag = 1'b0;
    logic [8:0] exp_q[$];
    int         sc[$];
    logic       m_last_valid = 1'b0;
    logic [7:0] m_last_addr = 8'h00;
    logic [7:0] last_din = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: every accepted write yields an address strobe (unless it targets
    // the register most recently written) followed by a data strobe, in order.
    task automatic mon();
        logic [8:0] ev;
        if (rst_n && req_valid && req_ready) begin
            acc_cyc  = cyc;
            acc_flag = 1'b1;
            if (!(m_last_valid && req_addr == m_last_addr))
                exp_q.push_back({1'b0, req_addr});
            exp_q.push_back({1'b1, req_data});
            m_last_valid = 1'b1;
            m_last_addr  = req_addr;
        end
        if (rst_n) begin
            check("wr_eq_cs", opm_wr_n, opm_cs_n);
            if (!opm_cs_n) begin
                sc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("spurious_strobe", opm_cs_n, 1'b1);
                end else begin
                    ev = exp_q.pop_front();
                    check("strobe_bus", {opm_a0, opm_din}, ev);
                end
                last_din = opm_din;
            end else begin
                check("din_hold", opm_din, last_din);
            end
        end
    endtask

    task automatic tick();
        @(negedge ymclk);
        mon();
        @(posedge ymclk);
        #1;
        cyc++;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] d);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        acc_flag  = 1'b0;
        while (!acc_flag && n < 100) begin
            tick();
            n++;
        end
        req_valid = 1'b0;
        check("push_accept", acc_flag, 1'b1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!idle && n < budget) begin
            tick();
            n++;
        end
        check(tag, idle, 1'b1);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last_valid = 1'b0;
        last_din     = 8'h00;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int n;
        int blocked;
        logic saw_full;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 8'h00;
        req_data  = 8'h00;
        opm_dout  = 8'h00;
        err_clr   = 1'b0;
        tick();
        tick();
        check("rst_ready", req_ready, 1'b0);
        check("rst_cs_n", opm_cs_n, 1'b1);
        check("rst_wr_n", opm_wr_n, 1'b1);
        check("rst_a0", opm_a0, 1'b0);
        check("rst_din", opm_din, 8'h00);
        check("rst_level", level, 4'd0);
        check("rst_idle", idle, 1'b1);
        check("rst_terr", timeout_err, 1'b0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", req_ready, 1'b1);

        // Single write: ADDR at +2, DATA at +5, idle after the first poll.
        sc.delete();
        push(8'h20, 8'hC7);
        a = acc_cyc;
        while (cyc < a + 10) tick();
        check("single_poll_busy", idle, 1'b0);
        tick();
        check("single_idle", idle, 1'b1);
        check("single_nstrobe", sc.size(), 2);
        if (sc.size() == 2) begin
            check("single_addr_cyc", sc[0], a + 2);
            check("single_data_cyc", sc[1], a + 5);
        end

        // Repeated register: second write skips the address phase.
        push(8'h28, 8'h4A);
        wait_idle("rep_idle1", 50);
        sc.delete();
        push(8'h28, 8'h3E);
        a = acc_cyc;
        wait_idle("rep_idle2", 50);
        check("rep_nstrobe", sc.size(), 1);
        if (sc.size() == 1) check("rep_data_cyc", sc[0], a + 2);

        // Fill the queue while the chip reports busy.
        opm_dout = 8'h80;
        blocked  = 0;
        saw_full = 1'b0;
        for (int i = 0; i < 10; i++) begin
            int k = 0;
            req_valid = 1'b1;
            req_addr  = 8'h30 | 8'(i & 1);
            req_data  = 8'(i * 17 + 3);
            acc_flag  = 1'b0;
            while (!acc_flag && k < 100) begin
                if (level == 4'd8) begin
                    check("ready_when_full", req_ready, 1'b0);
                    saw_full = 1'b1;
                    blocked++;
                    if (blocked >= 5) opm_dout = 8'h00;
                end
                tick();
                k++;
            end
            check("fill_accept", acc_flag, 1'b1);
        end
        req_valid = 1'b0;
        check("fill_reached_full", saw_full, 1'b1);
        opm_dout = 8'h00;
        wait_idle("fill_drain", 400);
        check("fill_sb_empty", exp_q.size(), 0);

        // Busy stuck high: sticky timeout, address re-sent, err_clr clears.
        opm_dout = 8'h80;
        push(8'h40, 8'h11);
        a = acc_cyc;
        n = 0;
        while (!timeout_err && n < 1200) begin
            tick();
            n++;
        end
        check("to_set", timeout_err, 1'b1);
        check("to_cycle", cyc, a + 1034);
        m_last_valid = 1'b0;
        repeat (60) tick();
        opm_dout = 8'h00;
        sc.delete();
        push(8'h40, 8'h22);
        wait_idle("to_resend_idle", 50);
        check("to_resend_nstrobe", sc.size(), 2);
        check("to_sticky", timeout_err, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_cleared", timeout_err, 1'b0);

        // Timeout coinciding with err_clr: the set wins for one cycle.
        opm_dout = 8'h80;
        err_clr  = 1'b1;
        push(8'h41, 8'h33);
        a = acc_cyc;
        n = 0;
        while (!timeout_err && n < 1200) begin
            tick();
            n++;
        end
        check("setwin_set", timeout_err, 1'b1);
        check("setwin_cycle", cyc, a + 1034);
        tick();
        check("setwin_clr", timeout_err, 1'b0);
        err_clr      = 1'b0;
        m_last_valid = 1'b0;
        opm_dout     = 8'h00;

        // Reset during the gap with three writes queued.
        push(8'h50, 8'h01);
        push(8'h51, 8'h02);
        push(8'h52, 8'h03);
        push(8'h53, 8'h04);
        check("gap_level_pre", level, 4'd3);
        rst_n = 1'b0;
        #1;
        check("gap_rst_cs", opm_cs_n, 1'b1);
        check("gap_rst_wr", opm_wr_n, 1'b1);
        check("gap_rst_level", level, 4'd0);
        check("gap_rst_idle", idle, 1'b1);
        check("gap_rst_ready", req_ready, 1'b0);
        check("gap_rst_din", opm_din, 8'h00);
        model_reset();
        tick();
        rst_n = 1'b1;
        sc.delete();
        repeat (20) tick();
        check("gap_no_strobe", sc.size(), 0);

        // Reset asserted during a data strobe releases the strobes at once.
        push(8'h60, 8'h77);
        a = acc_cyc;
        while (cyc < a + 5) tick();
        check("data_strobe_low", opm_cs_n, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_cs", opm_cs_n, 1'b1);
        check("async_wr", opm_wr_n, 1'b1);
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();

        // Random traffic with random busy durations.
        for (int i = 0; i < 600; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = 8'h20 + 8'($urandom_range(0, 2));
            req_data  = 8'($urandom);
            opm_dout  = {($urandom_range(0, 3) != 0), 7'($urandom)};
            tick();
        end
        req_valid = 1'b0;
        opm_dout  = 8'h00;
        wait_idle("rand_drain", 500);
        check("rand_sb_empty", exp_q.size(), 0);
        check("rand_level", level, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
